// File: rtl/alu_issue.sv
// alu_issue: decodes RV32I OP/OP-IMM into an ALU operand bundle behind a registered output FIFO
module alu_issue #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_rs1_data,
   input  logic [31:0] in_rs2_data,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] Op1,
   output logic [31:0] Op2,
   output logic [3:0]  Alu_Control,
   output logic [4:0]  out_rd,
   output logic        out_we,
   output logic        illegal,
   output logic [15:0] issued_count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);
   logic [6:0]    w_opc, w_f7;
   logic [2:0]    w_f3;
   logic          w_op, w_opi, w_sh, w_legal, w_accept, w_push, w_pop, w_unused;
   logic [31:0]   w_op2;
   logic [3:0]    w_ctrl;
   logic [AW:0]   r_count;
   logic [AW-1:0] r_wptr, r_rptr;
   logic          r_illegal;
   logic [15:0]   r_issued;
   logic [31:0]   r_op1 [DEPTH];
   logic [31:0]   r_op2 [DEPTH];
   logic [3:0]    r_ctrl [DEPTH];
   logic [4:0]    r_rd [DEPTH];
   logic          r_we [DEPTH];
   assign w_opc    = in_instr[6:0];
   assign w_f3     = in_instr[14:12];
   assign w_f7     = in_instr[31:25];
   assign w_unused = ^in_instr[19:15];
   // Decode: legality, second operand and ALU control; shift immediates are zero-extended shamt
   always_comb begin
      w_op    = w_opc == 7'b0110011;
      w_opi   = w_opc == 7'b0010011;
      w_sh    = w_opi & (w_f3[1:0] == 2'b01);
      w_legal = w_op  ? (w_f7 == 7'h00) | ((w_f7 == 7'h20) & ((w_f3 == 3'b000) | (w_f3 == 3'b101))) :
                w_opi ? ((w_f3 == 3'b001) ? (w_f7 == 7'h00) :
                         (w_f3 == 3'b101) ? ((w_f7 == 7'h00) | (w_f7 == 7'h20)) : 1'b1) : 1'b0;
      w_op2   = w_op ? in_rs2_data : w_sh ? {27'b0, in_instr[24:20]} : {{20{in_instr[31]}}, in_instr[31:20]};
      w_ctrl  = {w_f3, w_op ? in_instr[30] : (w_opi & (w_f3 == 3'b101) & in_instr[30])};
   end
   assign in_ready  = ~rst & ~flush & (r_count != L_DEPTH);
   assign w_accept  = in_valid & in_ready;
   assign w_push    = w_accept & w_legal;
   assign out_valid = r_count != '0;
   assign w_pop     = out_valid & out_ready;
   // FIFO occupancy, pointers, illegal pulse and handshake counter; flush empties but still counts a pop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count   <= '0;
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_illegal <= 1'b0;
         r_issued  <= '0;
      end else begin
         r_illegal <= w_accept & ~w_legal;
         r_issued  <= r_issued + 16'(w_pop);
         r_count   <= flush ? '0 : r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
         r_wptr    <= flush ? '0 : r_wptr + AW'(w_push);
         r_rptr    <= flush ? '0 : r_rptr + AW'(w_pop);
      end
   end
   // Entry storage written on a legal accept
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_op1[i]  <= '0;
            r_op2[i]  <= '0;
            r_ctrl[i] <= '0;
            r_rd[i]   <= '0;
            r_we[i]   <= 1'b0;
         end
      end else if (w_push) begin
         r_op1[r_wptr]  <= in_rs1_data;
         r_op2[r_wptr]  <= w_op2;
         r_ctrl[r_wptr] <= w_ctrl;
         r_rd[r_wptr]   <= in_instr[11:7];
         r_we[r_wptr]   <= in_instr[11:7] != 5'd0;
      end
   end
   assign Op1          = r_op1[r_rptr];
   assign Op2          = r_op2[r_rptr];
   assign Alu_Control  = r_ctrl[r_rptr];
   assign out_rd       = r_rd[r_rptr];
   assign out_we       = r_we[r_rptr];
   assign illegal      = r_illegal;
   assign issued_count = r_issued;
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed and random stimulus against a queue-based reference of the issue stage
module tb_alu_issue;
   localparam int DEPTH = 2;
   typedef struct {
      logic [31:0] op1;
      logic [31:0] op2;
      logic [3:0]  c;
      logic [4:0]  rd;
      logic        we;
   } ent_t;
   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, flush, out_valid, out_ready, out_we, illegal;
   logic [31:0] in_instr, in_rs1_data, in_rs2_data, Op1, Op2;
   logic [3:0]  Alu_Control;
   logic [4:0]  out_rd;
   logic [15:0] issued_count;
   int          checks = 0;
   int          failures = 0;
   ent_t        m_q[$];
   logic [15:0] m_cnt = '0;
   logic        m_ill = 1'b0;
   always #5 clk = ~clk;
   alu_issue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .Op1(Op1), .Op2(Op2), .Alu_Control(Alu_Control), .out_rd(out_rd),
      .out_we(out_we), .illegal(illegal), .issued_count(issued_count)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   function automatic void ref_dec(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                                   output bit ok, output ent_t e);
      bit [6:0] opc = i[6:0];
      bit [2:0] f3  = i[14:12];
      bit [6:0] f7  = i[31:25];
      ok = 0;
      e.op1 = a; e.op2 = 0; e.c = 0; e.rd = i[11:7]; e.we = (i[11:7] != 0);
      if (opc == 7'h33) begin
         ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
         e.op2 = b;
         e.c = {f3, i[30]};
      end else if (opc == 7'h13) begin
         if (f3 == 1) begin
            ok = (f7 == 0); e.op2 = 32'(i[24:20]); e.c = {f3, 1'b0};
         end else if (f3 == 5) begin
            ok = (f7 == 0) || (f7 == 7'h20); e.op2 = 32'(i[24:20]); e.c = {f3, i[30]};
         end else begin
            ok = 1; e.op2 = 32'($signed(i[31:20])); e.c = {f3, 1'b0};
         end
      end
   endfunction
   task automatic check_outs();
      chk("out_valid", out_valid, m_q.size() != 0);
      chk("illegal", illegal, m_ill);
      chk("issued_count", issued_count, m_cnt);
      if (m_q.size() != 0) begin
         chk("Op1", Op1, m_q[0].op1);
         chk("Op2", Op2, m_q[0].op2);
         chk("Alu_Control", Alu_Control, m_q[0].c);
         chk("out_rd", out_rd, m_q[0].rd);
         chk("out_we", out_we, m_q[0].we);
      end
   endtask
   task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                      input logic fl, input logic ordy);
      bit ok, acc, pp;
      ent_t e;
      in_valid = v; in_instr = ins; in_rs1_data = a; in_rs2_data = b; flush = fl; out_ready = ordy;
      #1;
      acc = v && m_q.size() < DEPTH && !fl;
      pp = m_q.size() != 0 && ordy;
      chk("in_ready", in_ready, m_q.size() < DEPTH && !fl);
      ref_dec(ins, a, b, ok, e);
      @(posedge clk); #1;
      if (pp) begin
         void'(m_q.pop_front());
         m_cnt++;
      end
      if (fl) m_q.delete();
      else if (acc && ok) m_q.push_back(e);
      m_ill = acc && !ok;
      check_outs();
   endtask
   task automatic check_zero(input string tag);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_op1"}, Op1, 0);
      chk({tag, "_op2"}, Op2, 0);
      chk({tag, "_ctrl"}, Alu_Control, 0);
      chk({tag, "_rd"}, out_rd, 0);
      chk({tag, "_we"}, out_we, 0);
      chk({tag, "_illegal"}, illegal, 0);
      chk({tag, "_cnt"}, issued_count, 0);
      chk({tag, "_ready"}, in_ready, 0);
   endtask
   function automatic logic [31:0] rnd_instr();
      logic [31:0] r = $urandom;
      int k = $urandom_range(0, 9);
      if (k < 4) r[6:0] = 7'h33;
      else if (k < 8) r[6:0] = 7'h13;
      if (k < 8 && $urandom_range(0, 1) == 1) r[31:25] = $urandom_range(0, 1) == 1 ? 7'h20 : 7'h00;
      return r;
   endfunction
   initial begin
      logic [15:0] base;
      int guard;
      rst = 1'b1; in_valid = 0; in_instr = 0; in_rs1_data = 0; in_rs2_data = 0; flush = 0; out_ready = 0;
      @(posedge clk); #1;
      check_zero("reset");
      rst = 1'b0;
      cyc(1, 32'h402081B3, 32'd10, 32'd3, 0, 1);
      chk("sub_op1", Op1, 32'd10);
      chk("sub_op2", Op2, 32'd3);
      chk("sub_ctrl", Alu_Control, 4'b0001);
      chk("sub_rd", out_rd, 5'd3);
      chk("sub_we", out_we, 1);
      cyc(1, 32'h40735293, $urandom, $urandom, 0, 1);
      chk("srai_op2", Op2, 32'd7);
      chk("srai_ctrl", Alu_Control, 4'b1011);
      cyc(1, 32'hFFF00093, 32'd0, $urandom, 0, 1);
      chk("addi_op2", Op2, 32'hFFFFFFFF);
      chk("addi_ctrl", Alu_Control, 4'b0000);
      cyc(0, 0, 0, 0, 0, 1);
      base = m_cnt;
      cyc(1, 32'h4020A1B3, 32'd5, 32'd6, 0, 1);
      chk("ill_pulse", illegal, 1);
      chk("ill_valid", out_valid, 0);
      chk("ill_cnt", issued_count, base);
      cyc(0, 0, 0, 0, 0, 0);
      chk("ill_one_cycle", illegal, 0);
      base = m_cnt;
      cyc(1, 32'h00208133, 32'd1, 32'd2, 0, 0);
      cyc(1, 32'h00418233, 32'd3, 32'd4, 0, 0);
      chk("bp_full_ready", in_ready, 0);
      cyc(1, 32'h006283B3, 32'd5, 32'd6, 0, 0);
      cyc(1, 32'h006283B3, 32'd5, 32'd6, 0, 1);
      cyc(1, 32'h006283B3, 32'd5, 32'd6, 0, 1);
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1);
      chk("bp_drained", issued_count, base + 16'd3);
      cyc(1, 32'h00100093, 32'd7, 0, 0, 0);
      cyc(1, 32'h00200113, 32'd8, 0, 0, 0);
      cyc(1, 32'h00300193, 32'd9, 0, 1, 0);
      chk("flush_valid", out_valid, 0);
      cyc(1, 32'h02A00213, 32'd11, 0, 0, 1);
      chk("post_flush_op1", Op1, 32'd11);
      chk("post_flush_op2", Op2, 32'd42);
      for (int n = 0; n < 400; n++)
         cyc($urandom_range(0, 3) != 0, rnd_instr(), $urandom, $urandom, $urandom_range(0, 15) == 0,
             $urandom_range(0, 3) != 0);
      guard = 0;
      while (m_cnt != 16'hFFFF && guard < 70000) begin
         logic [31:0] r = $urandom;
         r[6:0] = 7'h13;
         r[14:12] = 3'b000;
         cyc(1, r, $urandom, 0, 0, 1);
         guard++;
      end
      chk("preload_ffff", issued_count, 16'hFFFF);
      cyc(0, 0, 0, 0, 0, 1);
      chk("wrap_zero", issued_count, 16'h0000);
      cyc(1, 32'h00500293, 32'd1, 0, 0, 0);
      cyc(1, 32'h4020A1B3, 32'd1, 32'd2, 0, 0);
      rst = 1'b1;
      in_valid = 0;
      #1;
      check_zero("midrst");
      m_q.delete();
      m_cnt = 0;
      m_ill = 0;
      @(posedge clk); #1;
      check_zero("rst_hold");
      rst = 1'b0;
      for (int n = 0; n < 100; n++)
         cyc($urandom_range(0, 1), rnd_instr(), $urandom, $urandom, $urandom_range(0, 15) == 0,
             $urandom_range(0, 1));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
